sr_encode: RTL and testbench
============================

SR_ENCODE -- requirements
Module: sr_encode

Interface
REQ-001 Parameter ADDR_W, default 8, width of the program-memory write address counter.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clr  input  1  synchronous flush: empties pipeline, zeroes address counter and sticky error.
REQ-005 in_valid  input  1  request beat valid.
REQ-006 in_ready  output  1  encoder can accept a beat.
REQ-007 fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-008 op, rd, f3, rs1, rs2, f7  input  7/5/3/5/5/7  raw instruction fields.
REQ-009 imm  input  32  signed byte-offset or value immediate, full width.
REQ-010 out_valid  output  1  encoded word valid.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 instr  output  32  encoded RV32 instruction word.
REQ-013 out_addr  output  ADDR_W  word address for instr, for program-memory load.
REQ-014 err  output  1  current word's immediate or format was not representable.
REQ-015 err_sticky  output  1  set by any emitted err beat, cleared only by clr or reset.

Function
REQ-016 A beat transfers on in_valid & in_ready; an output transfers on out_valid & out_ready.
REQ-017 Two-stage pipeline:
- stage 1 registers the fields and computes the range check;
- stage 2 registers the packed word and err.
- Latency from input transfer to out_valid is exactly 2 cycles with out_ready held high.
REQ-018 Throughput is one beat per cycle.
- in_ready = !stage1_valid | stage2 can advance.
- stage2 can advance = !out_valid | out_ready.
- Under backpressure no beat is lost or duplicated.
REQ-019 Packing per format (instr[31:0], MSB first):
- R: f7, rs2, rs1, f3, rd, op.
- I: imm[11:0], rs1, f3, rd, op.
- S: imm[11:5], rs2, rs1, f3, imm[4:0], op.
- B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op.
- U: imm[31:12], rd, op.
- J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
REQ-020 err = 1 when any of the following holds:
- I or S: imm is not within -2048..2047.
- B: imm[0] = 1, or imm is not within -4096..4094.
- J: imm[0] = 1, or imm is not within -2^20..2^20-2.
- U: imm[11:0] != 0.
- fmt is 6 or 7.
- R never flags err.
REQ-021 On an err beat with a legal fmt, instr is still packed from the truncated immediate bits as in REQ-019.
REQ-022 On illegal fmt, instr = 32'h00000013 (NOP) with err = 1.
REQ-023 out_addr holds the address of the word currently presented.
- It increments by 1 after each output transfer.
- It wraps from 2^ADDR_W-1 to 0.
- It advances on err beats too.
REQ-024 instr, err and out_addr are stable while out_valid & !out_ready.
REQ-025 clr has priority over any simultaneous transfer.
- The next cycle has out_valid = 0, stage 1 empty, out_addr = 0, err_sticky = 0.
- Beats presented in the clr cycle are dropped.
REQ-026 err_sticky sets in the cycle after an output transfer with err = 1.

Reset
REQ-027 When rst_n = 0, asynchronously:
- out_valid = 0, stage-1 valid = 0, instr = 0, err = 0, err_sticky = 0, out_addr = 0;
- in_ready = 1 once rst_n deasserts.
REQ-028 Reset mid-operation discards all in-flight beats; no partial word is emitted after release.

Structure
REQ-029 The shared package shall hold:
- format codes (R, I, S, B, U, J);
- opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
- the NOP constant 32'h00000013.
REQ-030 A combinational sub-module sr_encode_pack holds the format packing and the range check; sr_encode holds the handshake, pipeline registers and counter.

Verification
REQ-031 R add x3,x1,x2 (op 0x33, f3 0, f7 0) -> instr 0x002081B3, err 0, out_addr 0, two cycles after accept.
REQ-032 I addi x1,x0,5 (op 0x13) -> 0x00500093; imm 2048 -> err 1, err_sticky 1; then clr -> err_sticky 0, out_addr 0.
REQ-033 B beq x0,x0,+8 (op 0x63) -> 0x00000463; imm 7 -> err 1.
- J jal x1,+16 (op 0x6F) -> 0x010000EF.
- U lui x5 with imm 0x12345000 (op 0x37) -> 0x123452B7.
REQ-034 Stream of 10 beats with out_ready toggled pseudo-randomly -> all 10 words emitted in order, no duplicates, out_addr 0..9, instr stable while stalled.
REQ-035 ADDR_W=2 with 5 beats -> out_addr sequence 0, 1, 2, 3, 0.
- fmt 7 -> instr 0x00000013, err 1.
- rst_n pulsed low with 2 beats in flight -> out_valid 0 and no stale word after release.

Source files
------------

// File: rtl/sr_encode_pkg.sv
// sr_encode_pkg -- shared definitions for the RV32 instruction encoder.
//   * format codes carried on the 3-bit fmt input
//   * base opcode constants
//   * canonical NOP word emitted for an unencodable format
//   * beat_t: the raw field bundle held by pipeline stage 1
//   * in_range(): signed range test used by the immediate checks
package sr_encode_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } beat_t;

    // True when the 32-bit two's-complement value lies within [lo, hi].
    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/sr_encode_pack.sv
// sr_encode_pack -- purely combinational format packer and immediate check.
//   i_beat  : raw fields (fmt, op, rd, f3, rs1, rs2, f7, imm)
//   o_instr : packed RV32 word (NOP for an illegal format)
//   o_err   : immediate not representable in the format, or illegal format
module sr_encode_pack
    import sr_encode_pkg::*;
(
    input  beat_t       i_beat,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic [31:0] w_imm;
    assign w_imm = i_beat.imm;

    always_comb begin
        o_instr = INSTR_NOP;
        o_err   = 1'b0;
        case (i_beat.fmt)
            FMT_R: begin
                o_instr = {i_beat.f7, i_beat.rs2, i_beat.rs1, i_beat.f3, i_beat.rd, i_beat.op};
            end
            FMT_I: begin
                o_instr = {w_imm[11:0], i_beat.rs1, i_beat.f3, i_beat.rd, i_beat.op};
                o_err   = !in_range(w_imm, -2048, 2047);
            end
            FMT_S: begin
                o_instr = {w_imm[11:5], i_beat.rs2, i_beat.rs1, i_beat.f3, w_imm[4:0], i_beat.op};
                o_err   = !in_range(w_imm, -2048, 2047);
            end
            FMT_B: begin
                // Branch offsets are halfword aligned; bit 0 is never encoded.
                o_instr = {w_imm[12], w_imm[10:5], i_beat.rs2, i_beat.rs1, i_beat.f3,
                           w_imm[4:1], w_imm[11], i_beat.op};
                o_err   = w_imm[0] || !in_range(w_imm, -4096, 4094);
            end
            FMT_U: begin
                // Upper immediate: the low 12 bits must already be clear.
                o_instr = {w_imm[31:12], i_beat.rd, i_beat.op};
                o_err   = |w_imm[11:0];
            end
            FMT_J: begin
                o_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_beat.rd, i_beat.op};
                o_err   = w_imm[0] || !in_range(w_imm, -1048576, 1048574);
            end
            default: begin
                o_instr = INSTR_NOP;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sr_encode.sv
// sr_encode -- two-stage valid/ready RV32 instruction encoder with a
// program-memory address counter.
//   clk, rst_n         : clock, asynchronous active-low reset
//   clr                : synchronous flush (pipeline, address, sticky error)
//   in_valid/in_ready  : request handshake; fmt/op/rd/f3/rs1/rs2/f7/imm fields
//   out_valid/out_ready: result handshake; instr, err, out_addr
//   err_sticky         : set by any transferred err word
// Stage 1 holds the raw fields; the packer/range check works on them and
// stage 2 captures the packed word and its err flag.
module sr_encode
    import sr_encode_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        op,
    input  logic [4:0]        rd,
    input  logic [2:0]        f3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        f7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              err_sticky
);

    beat_t              w_in_beat;
    beat_t              r_s1;
    logic               r_s1_valid;
    logic [31:0]        w_pack_instr;
    logic               w_pack_err;
    logic               w_s2_adv;
    logic               w_out_xfer;
    logic [31:0]        r_instr;
    logic               r_err;
    logic               r_out_valid;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_err_sticky;

    assign w_in_beat = {fmt, op, rd, f3, rs1, rs2, f7, imm};

    // Stage 2 may load whenever its current word is absent or leaving.
    assign w_s2_adv   = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_adv;
    assign w_out_xfer = r_out_valid && out_ready;

    sr_encode_pack u_pack (
        .i_beat  (r_s1),
        .o_instr (w_pack_instr),
        .o_err   (w_pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1         <= '0;
            r_s1_valid   <= 1'b0;
            r_instr      <= '0;
            r_err        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_addr       <= '0;
            r_err_sticky <= 1'b0;
        end else if (clr) begin
            // Flush wins over any handshake in the same cycle.
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_addr       <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1 <= w_in_beat;
                end
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_instr <= w_pack_instr;
                    r_err   <= w_pack_err;
                end
            end
            if (w_out_xfer) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (r_err) begin
                    r_err_sticky <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign instr      = r_instr;
    assign err        = r_err;
    assign out_addr   = r_addr;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_sr_encode.sv
module tb_sr_encode;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;

    logic        in_ready, out_valid, err, err_sticky;
    logic [31:0] instr;
    logic [7:0]  out_addr;

    logic        in_ready2, out_valid2, err2, err_sticky2;
    logic [31:0] instr2;
    logic [1:0]  out_addr2;

    int errors = 0;
    int checks = 0;

    sr_encode #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .rd(rd), .f3(f3), .rs1(rs1), .rs2(rs2), .f7(f7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .out_addr(out_addr),
        .err(err), .err_sticky(err_sticky)
    );

    sr_encode #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
        .fmt(fmt), .op(op), .rd(rd), .f3(f3), .rs1(rs1), .rs2(rs2), .f7(f7), .imm(imm),
        .out_valid(out_valid2), .out_ready(out_ready), .instr(instr2), .out_addr(out_addr2),
        .err(err2), .err_sticky(err_sticky2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f;
        logic [6:0]  o;
        logic [4:0]  d;
        logic [2:0]  fn3;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [6:0]  fn7;
        logic [31:0] im;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 17;
    localparam vec_t VECS [NVEC] = '{
        '{3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h00000000, 32'h002081B3, 1'b0}, // add x3,x1,x2
        '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5,        32'h00500093, 1'b0}, // addi x1,x0,5
        '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2047,     32'h7FF00093, 1'b0},
        '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0}, // -2048
        '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2048,     32'h80000093, 1'b1},
        '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd8,        32'h00000463, 1'b0}, // beq +8
        '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd7,        32'h00000363, 1'b1}, // odd
        '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd4094,     32'h7E000FE3, 1'b0},
        '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd4096,     32'h80000063, 1'b1},
        '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd16,       32'h010000EF, 1'b0}, // jal x1,+16
        '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0}, // lui x5
        '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345001, 32'h123452B7, 1'b1},
        '{3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd1, 7'h00, 32'd8,        32'h00112423, 1'b0}, // sw x1,8(x2)
        '{3'd7, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h00000000, 32'h00000013, 1'b1},
        '{3'd6, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h00000000, 32'h00000013, 1'b1},
        '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd1,        32'h000000EF, 1'b1}, // odd jal
        '{3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0}  // sub
    };

    // Presents one beat for exactly one cycle; assumes in_ready is high.
    task automatic drive_beat(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                              input logic [2:0] fn3, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [6:0] fn7, input logic [31:0] im);
        fmt = f; op = o; rd = d; f3 = fn3; rs1 = s1; rs2 = s2; f7 = fn7; imm = im;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || err_sticky !== 1'b0 || instr !== 32'h0 || out_addr !== 8'h0)
            $display("FAIL reset_state: got valid=%b err=%b sticky=%b instr=%h addr=%h required all zero",
                     out_valid, err, err_sticky, instr, out_addr);
        if (out_valid !== 1'b0 || err !== 1'b0 || err_sticky !== 1'b0 || instr !== 32'h0 || out_addr !== 8'h0)
            errors++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        $display("reset: checked");
    endtask

    task automatic test_latency();
        drive_beat(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || instr !== 32'h002081B3 || err !== 1'b0 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL latency_word: got valid=%b instr=%h err=%b addr=%0d required 1/002081b3/0/0",
                     out_valid, instr, err, out_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 8'd1) begin
            errors++;
            $display("FAIL latency_after: got valid=%b addr=%0d required 0/1", out_valid, out_addr);
        end
        $display("latency: add x3,x1,x2 -> %h", 32'h002081B3);
    endtask

    task automatic test_formats();
        do_clr();
        for (int i = 0; i < NVEC; i++) begin
            drive_beat(VECS[i].f, VECS[i].o, VECS[i].d, VECS[i].fn3, VECS[i].s1, VECS[i].s2,
                       VECS[i].fn7, VECS[i].im);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || instr !== VECS[i].exp_instr || err !== VECS[i].exp_err ||
                out_addr !== 8'(i)) begin
                errors++;
                $display("FAIL format_vec%0d: got valid=%b instr=%h err=%b addr=%0d required 1/%h/%b/%0d",
                         i, out_valid, instr, err, out_addr, VECS[i].exp_instr, VECS[i].exp_err, i);
            end else begin
                $display("format vec%0d: fmt=%0d imm=%h -> instr=%h err=%b", i, VECS[i].f, VECS[i].im,
                         instr, err);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_after_formats: got %b required 1", err_sticky);
        end
    endtask

    task automatic test_sticky_clr();
        do_clr();
        checks++;
        if (err_sticky !== 1'b0 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL clr_basic: got sticky=%b addr=%0d required 0/0", err_sticky, out_addr);
        end
        drive_beat(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2048);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || err !== 1'b1 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_pre: got valid=%b err=%b sticky=%b required 1/1/0", out_valid, err, err_sticky);
        end
        @(posedge clk); #1;
        checks++;
        if (err_sticky !== 1'b1 || out_addr !== 8'd1) begin
            errors++;
            $display("FAIL sticky_set: got sticky=%b addr=%0d required 1/1", err_sticky, out_addr);
        end
        // A beat presented together with clr must be dropped.
        fmt = 3'd0; op = 7'h33; rd = 5'd9; f3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0; f7 = 7'h00; imm = 32'h0;
        in_valid = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || err_sticky !== 1'b0 || out_addr !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_state: got valid=%b sticky=%b addr=%0d in_ready=%b required 0/0/0/1",
                     out_valid, err_sticky, out_addr, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_drop: got out_valid=%b after clr beat, required 0", out_valid);
        end
        $display("sticky/clr: checked");
    endtask

    task automatic test_backpressure();
        int got;
        logic hv;
        logic [31:0] hi;
        logic [7:0] ha;
        logic [31:0] exp_w;
        got = 0;
        hv = 1'b0;
        hi = '0;
        ha = '0;
        do_clr();
        fork
            begin : producer
                for (int i = 0; i < 10; i++) begin
                    logic acc;
                    int tries;
                    fmt = 3'd0; op = 7'h33; rd = 5'(i); f3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0;
                    f7 = 7'h00; imm = 32'h0;
                    in_valid = 1'b1;
                    acc = 1'b0;
                    tries = 0;
                    while (!acc && tries < 200) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        tries++;
                    end
                    if (!acc) begin
                        errors++;
                        checks++;
                        $display("FAIL bp_accept_timeout: got no accept for beat %0d, required accept", i);
                    end
                end
                in_valid = 1'b0;
            end
            begin : consumer
                for (int cyc = 0; cyc < 600 && got < 10; cyc++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (out_valid) begin
                        if (hv) begin
                            checks++;
                            if (instr !== hi || out_addr !== ha) begin
                                errors++;
                                $display("FAIL bp_stable: got instr=%h addr=%0d required %h/%0d",
                                         instr, out_addr, hi, ha);
                            end
                        end
                        if (out_ready) begin
                            exp_w = {20'd0, 5'(got), 7'h33};
                            checks++;
                            if (instr !== exp_w || out_addr !== 8'(got) || err !== 1'b0) begin
                                errors++;
                                $display("FAIL bp_word%0d: got instr=%h addr=%0d err=%b required %h/%0d/0",
                                         got, instr, out_addr, err, exp_w, got);
                            end else begin
                                $display("backpressure word%0d: instr=%h addr=%0d", got, instr, out_addr);
                            end
                            got++;
                            hv = 1'b0;
                        end else begin
                            hv = 1'b1;
                            hi = instr;
                            ha = out_addr;
                        end
                    end
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL bp_count: got %0d words required 10", got);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 8'd10) begin
            errors++;
            $display("FAIL bp_no_dup: got valid=%b addr=%0d required 0/10", out_valid, out_addr);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] wrap_exp [5];
        int n;
        wrap_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        n = 0;
        do_clr();
        fork
            begin
                for (int j = 0; j < 5; j++) begin
                    fmt = 3'd0; op = 7'h33; rd = 5'(j); f3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0;
                    f7 = 7'h00; imm = 32'h0;
                    in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (out_valid2) begin
                        checks++;
                        if (n >= 5) begin
                            errors++;
                            $display("FAIL wrap_extra: got extra word addr=%0d required none", out_addr2);
                        end else if (out_addr2 !== wrap_exp[n] || instr2 !== {20'd0, 5'(n), 7'h33}) begin
                            errors++;
                            $display("FAIL wrap_addr%0d: got addr=%0d instr=%h required %0d/%h",
                                     n, out_addr2, instr2, wrap_exp[n], {20'd0, 5'(n), 7'h33});
                        end else begin
                            $display("wrap word%0d: addr=%0d", n, out_addr2);
                        end
                        n++;
                    end
                end
            end
        join
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL wrap_count: got %0d words required 5", n);
        end
    endtask

    task automatic test_reset_midflight();
        logic stale;
        do_clr();
        fmt = 3'd0; op = 7'h33; rd = 5'd1; f3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0; f7 = 7'h00; imm = 32'h0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rd = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || instr !== 32'h0 || out_addr !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got valid=%b instr=%h addr=%0d err=%b required 0/0/0/0",
                     out_valid, instr, out_addr, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_stale: got stale=%b in_ready=%b required 0/1", stale, in_ready);
        end
        $display("reset mid-flight: checked");
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        fmt = '0; op = '0; rd = '0; f3 = '0; rs1 = '0; rs2 = '0; f7 = '0; imm = '0;
        test_reset();
        test_latency();
        test_formats();
        test_sticky_clr();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
